// File: rtl/pixel_map_select.sv
// pixel_map_select: selects one of NSRC pixel maps for display, switching
// sources only on frame boundaries with an optional run of blank frames
// between the old and the new source.
module pixel_map_select #(
    parameter int ROWS         = 20,
    parameter int COLS         = 10,
    parameter int CW           = 4,
    parameter int NSRC         = 3,
    parameter int BLANK_FRAMES = 1
) (
    input  logic                                    Clk,
    input  logic                                    Reset,
    input  logic [NSRC-1:0][ROWS-1:0][COLS-1:0][CW-1:0] src,
    input  logic                                    frame_start,
    input  logic [2:0]                              sel_req,
    input  logic                                    sel_valid,
    output logic                                    sel_ready,
    input  logic                                    freeze,
    output logic [ROWS-1:0][COLS-1:0][CW-1:0]       out,
    output logic [2:0]                              cur_sel,
    output logic                                    switching
);

    typedef logic [ROWS-1:0][COLS-1:0][CW-1:0] map_t;

    typedef enum logic [1:0] {
        SHOW  = 2'd0,
        PEND  = 2'd1,
        BLANK = 2'd2
    } state_t;

    // Value loaded into blank_cnt on entering BLANK; unused when no blank
    // frames are configured, so it is clamped to keep the expression legal.
    localparam logic [3:0] BLANK_LOAD = (BLANK_FRAMES == 0) ? 4'd0 : 4'(BLANK_FRAMES - 1);

    state_t     state, state_d;
    logic [2:0] cur_sel_d;
    logic [2:0] pend_sel, pend_sel_d;
    logic [3:0] blank_cnt, blank_cnt_d;
    map_t       out_d;
    map_t       src_map;

    // State, selection and displayed-map registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= SHOW;
            cur_sel   <= '0;
            pend_sel  <= '0;
            blank_cnt <= '0;
            out       <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, so ordering inside this block does not matter.
            state     <= state_d;
            cur_sel   <= cur_sel_d;
            pend_sel  <= pend_sel_d;
            blank_cnt <= blank_cnt_d;
            out       <= out_d;
        end
    end

    // Next-state logic: request acceptance and frame-boundary sequencing.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves a value
        // unassigned, which would otherwise infer a latch.
        state_d     = state;
        cur_sel_d   = cur_sel;
        pend_sel_d  = pend_sel;
        blank_cnt_d = blank_cnt;
        unique case (state)
            SHOW: begin
                // A frame_start in the accepting cycle is deliberately ignored;
                // the first boundary that counts is seen from PEND.
                if (sel_valid) begin
                    pend_sel_d = sel_req;
                    state_d    = PEND;
                end
            end
            PEND: begin
                if (frame_start) begin
                    if (BLANK_FRAMES == 0) begin
                        cur_sel_d = pend_sel;
                        state_d   = SHOW;
                    end else begin
                        blank_cnt_d = BLANK_LOAD;
                        state_d     = BLANK;
                    end
                end
            end
            BLANK: begin
                if (frame_start) begin
                    if (blank_cnt == 4'd0) begin
                        cur_sel_d = pend_sel;
                        state_d   = SHOW;
                    end else begin
                        blank_cnt_d = blank_cnt - 4'd1;
                    end
                end
            end
            default: state_d = SHOW;
        endcase
    end

    // Source mux: out-of-range selections display an empty board.
    always_comb begin
        src_map = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (cur_sel == 3'(i)) begin
                src_map = src[i];
            end
        end
    end

    // Outputs: handshake/status flags and the next displayed map.
    always_comb begin
        sel_ready = (state == SHOW);
        switching = (state != SHOW);
        if (state == BLANK) begin
            out_d = '0;
        end else if (freeze) begin
            out_d = out;
        end else begin
            out_d = src_map;
        end
    end

endmodule

// File: tb/tb_pixel_map_select.sv
// Directed testbench for pixel_map_select: one instance with a single blank
// frame between switches and one that switches without blanking.
module tb_pixel_map_select;

    localparam int ROWS = 20;
    localparam int COLS = 10;
    localparam int CW   = 4;
    localparam int NSRC = 3;
    localparam int MW   = ROWS * COLS * CW;

    typedef logic [ROWS-1:0][COLS-1:0][CW-1:0] map_t;

    logic                 Clk;
    logic                 Reset;
    logic [NSRC-1:0][ROWS-1:0][COLS-1:0][CW-1:0] src;

    logic       frame_start, sel_valid, freeze;
    logic [2:0] sel_req;
    logic       sel_ready, switching;
    logic [2:0] cur_sel;
    map_t       out;

    logic       b_frame_start, b_sel_valid, b_freeze;
    logic [2:0] b_sel_req;
    logic       b_sel_ready, b_switching;
    logic [2:0] b_cur_sel;
    map_t       b_out;

    int checks   = 0;
    int failures = 0;

    map_t held;
    map_t zero_map;

    pixel_map_select #(.ROWS(ROWS), .COLS(COLS), .CW(CW), .NSRC(NSRC), .BLANK_FRAMES(1)) dut (
        .Clk(Clk), .Reset(Reset), .src(src), .frame_start(frame_start),
        .sel_req(sel_req), .sel_valid(sel_valid), .sel_ready(sel_ready),
        .freeze(freeze), .out(out), .cur_sel(cur_sel), .switching(switching)
    );

    pixel_map_select #(.ROWS(ROWS), .COLS(COLS), .CW(CW), .NSRC(NSRC), .BLANK_FRAMES(0)) dut_b (
        .Clk(Clk), .Reset(Reset), .src(src), .frame_start(b_frame_start),
        .sel_req(b_sel_req), .sel_valid(b_sel_valid), .sel_ready(b_sel_ready),
        .freeze(b_freeze), .out(b_out), .cur_sel(b_cur_sel), .switching(b_switching)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_map(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bump_src0(input logic [3:0] v);
        src[0][0][0] = v;
        src[0][5][3] = ~v;
    endtask

    initial begin
        zero_map = '0;
        for (int i = 0; i < NSRC; i++)
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    src[i][r][c] = 4'(i * 7 + r * 3 + c + 1);
        src[0][0][0] = 4'h5;

        Reset = 1'b0;
        frame_start = 0; sel_valid = 0; freeze = 0; sel_req = 3'd0;
        b_frame_start = 0; b_sel_valid = 0; b_freeze = 0; b_sel_req = 3'd0;

        // Reset state
        step();
        step();
        check_map("rst_out", out, zero_map);
        check("rst_cur_sel", 8'(cur_sel), 8'd0);
        check("rst_switching", 8'(switching), 8'd0);
        check("rst_sel_ready", 8'(sel_ready), 8'd1);

        // Release: src[0] appears one cycle later
        Reset = 1'b1;
        step();
        check("rel_cell00", 8'(out[0][0]), 8'h05);
        check_map("rel_out", out, src[0]);
        check("rel_cur_sel", 8'(cur_sel), 8'd0);
        check("rel_switching", 8'(switching), 8'd0);

        // No-blank instance: switch to 1, no zero frame
        b_sel_req = 3'd1; b_sel_valid = 1;
        step();
        b_sel_valid = 0;
        check("b_switching_pend", 8'(b_switching), 8'd1);
        step();
        check("b_cur_sel_pend", 8'(b_cur_sel), 8'd0);
        check_map("b_out_pend", b_out, src[0]);
        b_frame_start = 1;
        step();
        b_frame_start = 0;
        check("b_cur_sel_new", 8'(b_cur_sel), 8'd1);
        check("b_switching_done", 8'(b_switching), 8'd0);
        check_map("b_out_edge", b_out, src[0]);
        step();
        check_map("b_out_new", b_out, src[1]);

        // Freeze holds out while src[0] changes every cycle
        held = src[0];
        freeze = 1;
        for (int k = 0; k < 3; k++) begin
            bump_src0(4'(k + 8));
            step();
            check_map("freeze_hold", out, held);
        end
        freeze = 0;
        step();
        check_map("unfreeze", out, src[0]);
        bump_src0(4'hC);
        step();
        check_map("follow", out, src[0]);

        // Switch to 2 with one blank frame; frame_start during accept ignored
        check("ready_show", 8'(sel_ready), 8'd1);
        sel_req = 3'd2; sel_valid = 1; frame_start = 1;
        step();
        sel_valid = 0; frame_start = 0;
        check("pend_switching", 8'(switching), 8'd1);
        check("pend_ready", 8'(sel_ready), 8'd0);
        check_map("pend_out_acc", out, src[0]);
        bump_src0(4'h3);
        step();
        check_map("pend_track", out, src[0]);
        check("pend_cur_sel", 8'(cur_sel), 8'd0);
        frame_start = 1;
        step();
        frame_start = 0;
        check_map("fs1_out", out, src[0]);
        check("blank_switching", 8'(switching), 8'd1);
        freeze = 1;
        step();
        check_map("blank_zero", out, zero_map);
        freeze = 0;
        step();
        check_map("blank_zero2", out, zero_map);
        frame_start = 1;
        step();
        frame_start = 0;
        check("sw2_cur_sel", 8'(cur_sel), 8'd2);
        check("sw2_switching", 8'(switching), 8'd0);
        check("sw2_ready", 8'(sel_ready), 8'd1);
        check_map("sw2_edge_zero", out, zero_map);
        step();
        check_map("sw2_out", out, src[2]);

        // Reset during BLANK abandons the switch
        sel_req = 3'd1; sel_valid = 1;
        step();
        sel_valid = 0;
        frame_start = 1;
        step();
        frame_start = 0;
        step();
        check("blank_before_rst", 8'(switching), 8'd1);
        Reset = 1'b0;
        #1;
        check_map("rst_blank_out", out, zero_map);
        check("rst_blank_switching", 8'(switching), 8'd0);
        check("rst_blank_ready", 8'(sel_ready), 8'd1);
        check("rst_blank_cur_sel", 8'(cur_sel), 8'd0);
        #1;
        Reset = 1'b1;
        step();
        check_map("rst_blank_src0", out, src[0]);

        // Second request while in PEND is ignored
        sel_req = 3'd2; sel_valid = 1;
        step();
        sel_req = 3'd1;
        step();
        sel_valid = 0;
        frame_start = 1;
        step();
        step();
        frame_start = 0;
        check("ignore_cur_sel", 8'(cur_sel), 8'd2);
        step();
        check_map("ignore_out", out, src[2]);

        // Out-of-range selection shows an empty board
        sel_req = 3'd7; sel_valid = 1;
        step();
        sel_valid = 0;
        frame_start = 1;
        step();
        step();
        frame_start = 0;
        step();
        check_map("oor_out", out, zero_map);
        check("oor_cur_sel", 8'(cur_sel), 8'd7);
        check("oor_ready", 8'(sel_ready), 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
